uart_rx: RTL and testbench

- Serial receiver downstream of uart_tx. It consumes the 8N1 serial stream that uart_tx drives on data_out and reassembles parallel bytes.
- It runs on a dedicated oversampling clock, rx_clk, at OVERSAMPLE × baud (16 × 9600 = 153.6 kHz nominal). It samples mid-bit, rejects glitch start bits and flags framing errors.
- Output is a byte plus a one-cycle done strobe, intended for a downstream FIFO or register bank.

---
 rtl/uart_rx.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver on an OVERSAMPLE x baud clock: two-flop line synchronizer,
// mid-bit sampling, glitch start rejection and stop-bit framing check.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 rx_clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 data_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 frame_err
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 frame_err_q, frame_err_d;
  logic                 line_s;

  assign line_s = sync2_q;

  // Next-state and output decode for the receive FSM.
  always_comb begin
    sync1_d     = data_in;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    start_d     = 1'b0;
    done_d      = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en && !line_s) begin
          state_d = ST_START;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end

      // Re-check the line half a bit in so short low glitches are dropped.
      ST_START: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_HALF) begin
          if (!line_s) begin
            start_d   = 1'b1;
            state_d   = ST_DATA;
            cnt_d     = CNT_ZERO;
            bit_idx_d = BIT_ZERO;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DATA: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          shift_d = {line_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = CNT_ZERO;
          if (bit_idx_q == BIT_LAST) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // Returning to IDLE at the stop midpoint leaves half a bit to catch the next start.
      ST_STOP: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = CNT_ZERO;
          if (line_s) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_WAIT_IDLE: begin
        if (line_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, synchronizer and registered outputs; synchronizer resets to idle-high.
  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      cnt_q       <= CNT_ZERO;
      bit_idx_q   <= BIT_ZERO;
      shift_q     <= {DATA_BITS{1'b0}};
      data_q      <= {DATA_BITS{1'b0}};
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data_out  = data_q;
  assign start     = start_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames
// checked against a byte-level model of what the receiver should deliver.
module tb_uart_rx;
  localparam int OS = 16;
  localparam int DB = 8;

  logic          rx_clk = 1'b0;
  logic          rst;
  logic          en;
  logic          data_in;
  logic [DB-1:0] data_out;
  logic          start;
  logic          busy;
  logic          done;
  logic          frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int start_cnt = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int excl_cnt = 0;
  int last_start_cyc = 0;
  int last_fall_cyc = 0;
  int done_cyc_q[$];
  logic [7:0] rx_q[$];

  logic [7:0] exp_data;
  logic       busy_pre, busy_post;
  logic [7:0] snap_out;
  logic [3:0] snap_flags;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .rx_clk(rx_clk), .rst(rst), .en(en), .data_in(data_in),
    .data_out(data_out), .start(start), .busy(busy), .done(done), .frame_err(frame_err)
  );

  always #5 rx_clk = ~rx_clk;

  always @(posedge rx_clk) cyc <= cyc + 1;

  // Pulse monitor sampled on the falling edge.
  always @(negedge rx_clk) begin
    if (start === 1'b1) begin
      start_cnt++;
      last_start_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc_q.push_back(cyc);
      rx_q.push_back(data_out);
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if ((done === 1'b1 && frame_err === 1'b1) || (start === 1'b1 && (done === 1'b1 || frame_err === 1'b1)))
      excl_cnt++;
  end

  task automatic idle(input int n);
    data_in = 1'b1;
    repeat (n) @(negedge rx_clk);
  endtask

  // Drives start, LSB-first data, stop; optionally drops en or asserts rst mid data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int drop_bit, input int rst_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    last_fall_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      data_in = frame[i];
      if (i >= 1 && i <= DB && (i - 1) == drop_bit) begin
        repeat (OS / 2) @(negedge rx_clk);
        busy_pre = busy;
        en = 1'b0;
        @(negedge rx_clk);
        busy_post = busy;
        repeat (OS / 2 - 1) @(negedge rx_clk);
      end else if (i >= 1 && i <= DB && (i - 1) == rst_bit) begin
        repeat (OS / 2) @(negedge rx_clk);
        rst = 1'b0;
        #1;
        snap_out = data_out;
        snap_flags = {start, busy, done, frame_err};
        repeat (OS / 2) @(negedge rx_clk);
      end else begin
        repeat (OS) @(negedge rx_clk);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; data_in = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({data_out, start, busy, done, frame_err} !== 12'h000) begin
      errors++;
      $display("FAIL reset_async outputs=%h required 000", {data_out, start, busy, done, frame_err});
    end
    repeat (3) @(negedge rx_clk);
    rst = 1'b1;
    repeat (3) @(negedge rx_clk);
    exp_data = 8'h00;
    checks++;
    if (busy !== 1'b0 || data_out !== exp_data) begin
      errors++;
      $display("FAIL reset_release busy=%b data_out=%h required busy=0 data_out=%h", busy, data_out, exp_data);
    end
  endtask

  task automatic test_basic;
    int s0 = start_cnt;
    int d0 = done_cnt;
    int lat;
    done_cyc_q.delete();
    send_frame(8'hA5, 1'b1, -1, -1);
    exp_data = 8'hA5;
    idle(4);
    checks++;
    if (start_cnt - s0 !== 1) begin
      errors++; $display("FAIL basic_start_count got=%0d required 1", start_cnt - s0);
    end
    // Half a bit (8) plus the same 2..3 cycle synchronizer/FSM delay that the done latency carries, +/-1.
    lat = last_start_cyc - last_fall_cyc;
    checks++;
    if (lat < 9 || lat > 12) begin
      errors++; $display("FAIL basic_start_latency got=%0d required 9..12", lat);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++; $display("FAIL basic_done_count got=%0d required 1", done_cnt - d0);
    end
    lat = (done_cyc_q.size() > 0) ? done_cyc_q[0] - last_fall_cyc : -1;
    checks++;
    if (lat < 153 || lat > 156) begin
      errors++; $display("FAIL basic_done_latency got=%0d required 153..156", lat);
    end
    checks++;
    if (data_out !== exp_data) begin
      errors++; $display("FAIL basic_data got=%h required %h", data_out, exp_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL basic_busy_after got=%b required 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    done_cyc_q.delete();
    rx_q.delete();
    send_frame(8'h00, 1'b1, -1, -1);
    send_frame(8'hFF, 1'b1, -1, -1);
    exp_data = 8'hFF;
    idle(4);
    checks++;
    if (done_cyc_q.size() !== 2) begin
      errors++; $display("FAIL b2b_done_count got=%0d required 2", done_cyc_q.size());
    end else begin
      checks++;
      if (done_cyc_q[1] - done_cyc_q[0] !== 160) begin
        errors++; $display("FAIL b2b_spacing got=%0d required 160", done_cyc_q[1] - done_cyc_q[0]);
      end
      checks++;
      if (rx_q[0] !== 8'h00 || rx_q[1] !== 8'hFF) begin
        errors++; $display("FAIL b2b_bytes got=%h,%h required 00,ff", rx_q[0], rx_q[1]);
      end
    end
    checks++;
    if (data_out !== exp_data) begin
      errors++; $display("FAIL b2b_data got=%h required %h", data_out, exp_data);
    end
  endtask

  task automatic test_glitch;
    int s0 = start_cnt;
    int d0 = done_cnt;
    data_in = 1'b0;
    repeat (4) @(negedge rx_clk);
    data_in = 1'b1;
    repeat (8) @(negedge rx_clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL glitch_busy_12 got=%b required 0", busy);
    end
    idle(8);
    checks++;
    if (start_cnt !== s0 || done_cnt !== d0 || data_out !== exp_data) begin
      errors++;
      $display("FAIL glitch_quiet starts=%0d dones=%0d data=%h required 0 0 %h",
               start_cnt - s0, done_cnt - d0, data_out, exp_data);
    end
  endtask

  task automatic test_frame_err;
    int d0 = done_cnt;
    int f0 = ferr_cnt;
    int s0 = start_cnt;
    send_frame(8'h3C, 1'b0, -1, -1);
    repeat (40) @(negedge rx_clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL ferr_busy_held got=%b required 1", busy);
    end
    checks++;
    if (ferr_cnt - f0 !== 1 || done_cnt !== d0 || start_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL ferr_pulses ferr=%0d done=%0d start=%0d required 1 0 1",
               ferr_cnt - f0, done_cnt - d0, start_cnt - s0);
    end
    checks++;
    if (data_out !== exp_data) begin
      errors++; $display("FAIL ferr_data got=%h required %h", data_out, exp_data);
    end
    idle(6);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL ferr_busy_release got=%b required 0", busy);
    end
  endtask

  task automatic test_en_drop;
    int d0 = done_cnt;
    send_frame(8'h6E, 1'b1, 3, -1);
    checks++;
    if (busy_pre !== 1'b1 || busy_post !== 1'b0) begin
      errors++; $display("FAIL endrop_busy pre=%b post=%b required 1 0", busy_pre, busy_post);
    end
    checks++;
    if (done_cnt !== d0 || data_out !== exp_data) begin
      errors++; $display("FAIL endrop_quiet dones=%0d data=%h required 0 %h", done_cnt - d0, data_out, exp_data);
    end
    en = 1'b1;
    idle(4);
    send_frame(8'h5A, 1'b1, -1, -1);
    exp_data = 8'h5A;
    idle(4);
    checks++;
    if (data_out !== exp_data || done_cnt - d0 !== 1) begin
      errors++; $display("FAIL endrop_next data=%h dones=%0d required %h 1", data_out, done_cnt - d0, exp_data);
    end
  endtask

  task automatic test_mid_reset;
    int d0;
    send_frame(8'hC3, 1'b1, -1, 5);
    exp_data = 8'h00;
    checks++;
    if (snap_out !== 8'h00 || snap_flags !== 4'h0) begin
      errors++; $display("FAIL rst_async data=%h flags=%b required 00 0000", snap_out, snap_flags);
    end
    rst = 1'b1;
    idle(4);
    d0 = done_cnt;
    send_frame(8'h81, 1'b1, -1, -1);
    exp_data = 8'h81;
    idle(4);
    checks++;
    if (data_out !== exp_data || done_cnt - d0 !== 1) begin
      errors++; $display("FAIL rst_next data=%h dones=%0d required %h 1", data_out, done_cnt - d0, exp_data);
    end
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    int d0 = done_cnt;
    int f0 = ferr_cnt;
    int exp_ferr = 0;
    logic [7:0] b;
    logic bad;
    rx_q.delete();
    for (int n = 0; n < 16; n++) begin
      b = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 4) == 0);
      send_frame(b, !bad, -1, -1);
      if (bad) begin
        exp_ferr++;
        idle(2 * OS);
      end else begin
        exp_data = b;
        exp_q.push_back(b);
      end
      checks++;
      if (data_out !== exp_data) begin
        errors++; $display("FAIL rand_data[%0d] got=%h required %h", n, data_out, exp_data);
      end
      idle($urandom_range(0, 40));
    end
    idle(4);
    checks++;
    if (done_cnt - d0 !== exp_q.size() || ferr_cnt - f0 !== exp_ferr) begin
      errors++;
      $display("FAIL rand_counts done=%0d ferr=%0d required %0d %0d",
               done_cnt - d0, ferr_cnt - f0, exp_q.size(), exp_ferr);
    end
    checks++;
    if (rx_q != exp_q) begin
      errors++; $display("FAIL rand_stream got=%p required %p", rx_q, exp_q);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_en_drop();
    test_mid_reset();
    test_random();
    checks++;
    if (excl_cnt !== 0) begin
      errors++; $display("FAIL pulse_exclusive overlaps=%0d required 0", excl_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
